// File: rtl/riscv_clint.sv
// Core-local interruptor: the mtime counter with prescaler, mtimecmp, and msip.
// A single-cycle request port gives a registered response one cycle after each accepted request.
module riscv_clint #(
  parameter logic [63:0] CLINT_BASE   = 64'h0200_0000,
  parameter logic [63:0] MSIP_OFF     = 64'h0,
  parameter logic [63:0] MTIMECMP_OFF = 64'h4000,
  parameter logic [63:0] MTIME_OFF    = 64'hBFF8,
  parameter int unsigned TICK_DIV     = 1
) (
  input  logic        i_riscv_clk,
  input  logic        i_riscv_rst_n,
  input  logic        i_riscv_clint_valid,
  input  logic        i_riscv_clint_we,
  input  logic [63:0] i_riscv_clint_addr,
  input  logic [63:0] i_riscv_clint_wdata,
  input  logic [7:0]  i_riscv_clint_wstrb,
  output logic        o_riscv_clint_rvalid,
  output logic [63:0] o_riscv_clint_rdata,
  output logic        o_riscv_clint_err,
  output logic        o_riscv_clint_mti,
  output logic        o_riscv_clint_msi,
  output logic [63:0] o_riscv_clint_mtime
);

  // TICK_DIV is at most 256, so the prescaler always fits in 8 bits.
  localparam logic [7:0]  TickMax      = 8'(TICK_DIV - 1);
  localparam logic [63:0] MsipAddr     = CLINT_BASE + MSIP_OFF;
  localparam logic [63:0] MtimecmpAddr = CLINT_BASE + MTIMECMP_OFF;
  localparam logic [63:0] MtimeAddr    = CLINT_BASE + MTIME_OFF;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  logic [7:0]  presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        mti_q, mti_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [63:0] rdata_q, rdata_d;

  logic aligned, sel_msip, sel_mtimecmp, sel_mtime, hit, wr_en, tick;

  // Address decode and the tick condition.
  always_comb begin
    aligned      = (i_riscv_clint_addr[2:0] == 3'b000);
    sel_msip     = aligned && (i_riscv_clint_addr == MsipAddr);
    sel_mtimecmp = aligned && (i_riscv_clint_addr == MtimecmpAddr);
    sel_mtime    = aligned && (i_riscv_clint_addr == MtimeAddr);
    hit          = sel_msip || sel_mtimecmp || sel_mtime;
    wr_en        = i_riscv_clint_valid && i_riscv_clint_we && hit;
    tick         = (presc_q == TickMax);
  end

  // Next-state for the timer, the compare and msip registers, and the response.
  always_comb begin
    presc_d    = tick ? 8'd0 : presc_q + 8'd1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    rvalid_d   = i_riscv_clint_valid;
    err_d      = i_riscv_clint_valid && !hit;
    rdata_d    = '0;

    // Unwritten mtime bytes keep the already-incremented value.
    if (wr_en && sel_mtime) begin
      mtime_d = merge_bytes(mtime_d, i_riscv_clint_wdata, i_riscv_clint_wstrb);
    end
    if (wr_en && sel_mtimecmp) begin
      mtimecmp_d = merge_bytes(mtimecmp_q, i_riscv_clint_wdata, i_riscv_clint_wstrb);
    end
    if (wr_en && sel_msip && i_riscv_clint_wstrb[0]) begin
      msip_d = i_riscv_clint_wdata[0];
    end

    if (i_riscv_clint_valid && !i_riscv_clint_we) begin
      unique case ({sel_msip, sel_mtimecmp, sel_mtime})
        3'b100:  rdata_d = {63'b0, msip_q};
        3'b010:  rdata_d = mtimecmp_q;
        3'b001:  rdata_d = mtime_q;
        default: rdata_d = '0;
      endcase
    end

    // Compare the values being loaded so mti lines up with the updated registers.
    mti_d = (mtime_d >= mtimecmp_d);
  end

  // State registers with synchronous active-low reset; a request in a reset cycle is dropped.
  always_ff @(posedge i_riscv_clk) begin
    if (!i_riscv_rst_n) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mti_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mti_q      <= mti_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign o_riscv_clint_rvalid = rvalid_q;
  assign o_riscv_clint_rdata  = rdata_q;
  assign o_riscv_clint_err    = err_q;
  assign o_riscv_clint_mti    = mti_q;
  assign o_riscv_clint_msi    = msip_q;
  assign o_riscv_clint_mtime  = mtime_q;

endmodule
